// File: rtl/bip_pkg.sv
// Shared BIP I constants (program memory geometry, HLT opcode), the loader state
// encoding, and the byte checksum fold used by the program loader.
package bip_pkg;

    localparam int unsigned PROG_ADDR_W = 11;
    localparam int unsigned PROG_DATA_W = 16;
    localparam logic [4:0]  HLT_OPCODE_DEF = 5'b00000;

    typedef enum logic [1:0] {
        LD_RECV_HI   = 2'b00,
        LD_RECV_LO   = 2'b01,
        LD_RECV_CSUM = 2'b10,
        LD_DONE      = 2'b11
    } loader_state_e;

    // Running XOR checksum over received program bytes.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Assembles UART bytes into 16-bit instructions and writes them into program memory
// from address 0 until HLT or full. Optional trailing checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import bip_pkg::*;
#(
    parameter int unsigned ADDR_W     = PROG_ADDR_W,
    parameter int unsigned DATA_W     = PROG_DATA_W,
    parameter logic [4:0]  HLT_OPCODE = HLT_OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              load_done,
    output logic              overflow,
    output logic              checksum_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] RECV_HI = LD_RECV_HI;
    localparam logic [1:0] RECV_LO = LD_RECV_LO;
    localparam logic [1:0] DONE    = LD_DONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [1:0] RECV_CSUM = LD_RECV_CSUM;
`endif
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [1:0]        state_r;
    logic [7:0]        hi_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] word_s;
    logic              is_hlt_s;
    logic              at_last_s;

    // Decode the word being completed and whether the write address is the last one.
    always_comb begin
        word_s    = {hi_r, rx_data};
        is_hlt_s  = (word_s[DATA_W-1 -: 5] == HLT_OPCODE);
        at_last_s = (addr_r == ADDR_LAST);
    end

    // Loader FSM, write port registers, address and word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RECV_HI;
            hi_r       <= 8'h00;
            addr_r     <= {ADDR_W{1'b0}};
            wr_en      <= 1'b0;
            wr_addr    <= {ADDR_W{1'b0}};
            wr_data    <= {DATA_W{1'b0}};
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            word_count <= {(ADDR_W+1){1'b0}};
        end else begin
            wr_en <= 1'b0;
            // The counter saturates at the last address; DONE is already entered by then.
            if (wr_en) begin
                word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
                if (!at_last_s) begin
                    addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    addr_r <= addr_r;
                end
            end else begin
                addr_r <= addr_r;
            end

            case (state_r)
                RECV_HI: begin
                    if (rx_valid) begin
                        hi_r    <= rx_data;
                        state_r <= RECV_LO;
                    end else begin
                        state_r <= RECV_HI;
                    end
                end
                RECV_LO: begin
                    if (rx_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_r;
                        wr_data <= word_s;
                        if (is_hlt_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_r <= RECV_CSUM;
`else
                            state_r   <= DONE;
                            load_done <= 1'b1;
`endif
                        end else if (at_last_s) begin
                            overflow  <= 1'b1;
                            load_done <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            state_r <= RECV_HI;
                        end
                    end else begin
                        state_r <= RECV_LO;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                RECV_CSUM: begin
                    if (rx_valid) begin
                        load_done <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= RECV_CSUM;
                    end
                end
`endif
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= RECV_HI;
                end
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] acc_r;

    // Fold every program byte (including the HLT word) and compare against the trailer byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r        <= 8'h00;
            checksum_err <= 1'b0;
        end else begin
            if (rx_valid && ((state_r == RECV_HI) || (state_r == RECV_LO))) begin
                acc_r <= csum_fold(acc_r, rx_data);
            end else begin
                acc_r <= acc_r;
            end
            if (rx_valid && (state_r == RECV_CSUM)) begin
                checksum_err <= (rx_data != acc_r);
            end else begin
                checksum_err <= checksum_err;
            end
        end
    end
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default build and PROGRAM_LOADER_CHECKSUM_EN).
module tb_program_loader;
    import bip_pkg::*;

    localparam int AW = PROG_ADDR_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic          ld;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          load_done;
    logic          overflow;
    logic          checksum_err;
    logic [AW:0]   word_count;

    int  errors = 0;
    int  checks = 0;
    wr_t log_q[$];

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done),
        .overflow(overflow), .checksum_err(checksum_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every write with the load_done value seen in the same cycle.
    always @(negedge clk) begin
        if (wr_en) log_q.push_back({wr_addr, wr_data, load_done});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_eq({tag, " rst wr_en"}, 32'(wr_en), 32'd0);
        check_eq({tag, " rst wr_addr"}, 32'(wr_addr), 32'd0);
        check_eq({tag, " rst wr_data"}, 32'(wr_data), 32'd0);
        check_eq({tag, " rst flags"}, {29'd0, load_done, overflow, checksum_err}, 32'd0);
        check_eq({tag, " rst word_count"}, 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic send_stream(input byte_q_t b, input bit b2b);
        foreach (b[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b[i];
            if (!b2b) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_three(input string p);
        logic [15:0] exp_d[3];
        exp_d = '{16'h0805, 16'h1803, 16'h0000};
        check_eq({p, " nwrites"}, 32'(log_q.size()), 32'd3);
        if (log_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("%s w%0d addr", p, i), 32'(log_q[i].a), 32'(i));
                check_eq($sformatf("%s w%0d data", p, i), 32'(log_q[i].d), 32'(exp_d[i]));
            end
            check_eq({p, " done@w1"}, 32'(log_q[0].ld), 32'd0);
            check_eq({p, " done@w3"}, 32'(log_q[2].ld), 32'(!CSUM));
        end
        check_eq({p, " word_count"}, 32'(word_count), 32'd3);
        check_eq({p, " load_done"}, 32'(load_done), 32'd1);
        check_eq({p, " overflow"}, 32'(overflow), 32'd0);
        check_eq({p, " checksum_err"}, 32'(checksum_err), 32'd0);
    endtask

    initial begin
        byte_q_t three;
        byte_q_t q;
        logic [AW-1:0] s_addr;
        logic [15:0]   s_data;
        logic [AW:0]   s_cnt;
        logic [2:0]    s_flags;
        int            bad;

        three = '{8'h08, 8'h05, 8'h18, 8'h03, 8'h00, 8'h00};
        if (CSUM) three.push_back(8'h16);

        // Three-word load with idle cycles between strobes
        do_reset("gap");
        send_stream(three, 1'b0);
        idle(3);
        check_three("gap");

        // Same stream, strobes on consecutive cycles
        do_reset("b2b");
        send_stream(three, 1'b1);
        idle(3);
        check_three("b2b");

        // Strobes after DONE change nothing
        s_addr  = wr_addr;
        s_data  = wr_data;
        s_cnt   = word_count;
        s_flags = {load_done, overflow, checksum_err};
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(8'h55);
        send_stream(q, 1'b1);
        idle(3);
        check_eq("post nwrites", 32'(log_q.size()), 32'd3);
        check_eq("post wr_addr", 32'(wr_addr), 32'(s_addr));
        check_eq("post wr_data", 32'(wr_data), 32'(s_data));
        check_eq("post word_count", 32'(word_count), 32'(s_cnt));
        check_eq("post flags", 32'({load_done, overflow, checksum_err}), 32'(s_flags));

        // Reset discards a partial word
        do_reset("mid0");
        send_stream('{8'h12}, 1'b0);
        do_reset("mid1");
        send_stream('{8'h34, 8'h56}, 1'b0);
        idle(3);
        check_eq("mid nwrites", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) begin
            check_eq("mid addr", 32'(log_q[0].a), 32'd0);
            check_eq("mid data", 32'(log_q[0].d), 32'h3456);
        end
        check_eq("mid word_count", 32'(word_count), 32'd1);
        check_eq("mid load_done", 32'(load_done), 32'd0);

        // Fill all 2048 words without HLT
        do_reset("ovf");
        q.delete();
        for (int i = 0; i < 2048; i++) begin
            q.push_back(8'h08);
            q.push_back(i[7:0]);
        end
        send_stream(q, 1'b1);
        idle(3);
        check_eq("ovf nwrites", 32'(log_q.size()), 32'd2048);
        bad = 0;
        foreach (log_q[i]) begin
            if ((log_q[i].a != i[AW-1:0]) || (log_q[i].d != {8'h08, i[7:0]})) bad++;
        end
        check_eq("ovf sequence", 32'(bad), 32'd0);
        if (log_q.size() == 2048) begin
            check_eq("ovf last addr", 32'(log_q[2047].a), 32'd2047);
            check_eq("ovf last data", 32'(log_q[2047].d), 32'h08FF);
            check_eq("ovf done@last", 32'(log_q[2047].ld), 32'd1);
        end
        check_eq("ovf overflow", 32'(overflow), 32'd1);
        check_eq("ovf load_done", 32'(load_done), 32'd1);
        check_eq("ovf word_count", 32'(word_count), 32'd2048);
        check_eq("ovf checksum_err", 32'(checksum_err), 32'd0);
        send_stream('{8'h08, 8'h01}, 1'b1);
        idle(3);
        check_eq("ovf extra word", 32'(log_q.size()), 32'd2048);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Good and bad checksum trailers; load_done follows the trailer strobe by one cycle
        for (int k = 0; k < 2; k++) begin
            do_reset("csum");
            send_stream('{8'h08, 8'h05, 8'h00, 8'h00}, 1'b0);
            idle(2);
            check_eq("csum done before", 32'(load_done), 32'd0);
            rx_valid = 1'b1;
            rx_data  = (k == 0) ? 8'h0D : 8'h0C;
            @(negedge clk);
            rx_valid = 1'b0;
            check_eq("csum done after", 32'(load_done), 32'd1);
            check_eq("csum err", 32'(checksum_err), 32'(k));
            check_eq("csum nwrites", 32'(log_q.size()), 32'd2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Write-side companion to the BIP I program memory. Receives a byte stream from the UART receiver, assembles 16-bit instruction words (high byte first) and writes them sequentially into the 2048 x 16 program memory write port, starting at address 0. Loading ends on the first HLT instruction or when memory is full. `load_done` then releases the CPU from hold.

## Interface
Parameters:
- `ADDR_W`, 11: program memory address width.
- `DATA_W`, 16: instruction width. Fixed at 2 bytes; other values are unsupported.
- `HLT_OPCODE`, 5'b00000: value of `wr_data[15:11]` that terminates loading.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: received byte from the UART receiver.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `wr_en`, output, 1: program memory write enable, one-cycle pulse per word.
- `wr_addr`, output, ADDR_W: write address.
- `wr_data`, output, DATA_W: write data.
- `load_done`, output, 1: loading finished; sticky until reset.
- `overflow`, output, 1: memory filled without an HLT; sticky.
- `checksum_err`, output, 1: checksum mismatch; sticky. Tied 0 unless the checksum feature is compiled in.
- `word_count`, output, ADDR_W+1: number of words written (0..2048).

## Operation
States: `RECV_HI`, `RECV_LO`, `RECV_CSUM` (only with the checksum feature), `DONE`. Reset state is `RECV_HI`.
- **RECV_HI**, on `rx_valid`: latch `rx_data` into the high-byte register; go to `RECV_LO`.
- **RECV_LO**, on `rx_valid`:
  - Register `wr_data = {hi, rx_data}` and `wr_addr = addr`, and set `wr_en = 1` for the next cycle.
  - Next state:
    - `wr_data[15:11] == HLT_OPCODE`: `RECV_CSUM` if the checksum feature is compiled in, else `DONE`.
    - Else `addr == 2**ADDR_W-1`: set `overflow`; go to `DONE` (no checksum byte expected).
    - Else: return to `RECV_HI`.
- **Address counter**: 11-bit. Increments, and `word_count` increments, in the cycle `wr_en` is high. At address 2047 the counter does not wrap: `DONE` is entered first.
- **DONE**: `load_done = 1`. All further `rx_valid` strobes are ignored. `wr_en` never asserts again. Only reset leaves `DONE`.
- The HLT word itself is written to memory and counted.
- `rx_valid` is never lost. Because the write pulse overlaps `RECV_HI`, a byte arriving in the `wr_en` cycle is accepted as the next high byte.
- **Reset mid-load**: all state clears immediately. The next byte is treated as a high byte at address 0. A partially assembled word is discarded and never written.
- **Reset values**: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `load_done=0`, `overflow=0`, `checksum_err=0`, `word_count=0`.

## Timing
- Latency from the low-byte `rx_valid` cycle (cycle N) to `wr_en` high: 1 cycle (cycle N+1).
- `wr_addr` and `wr_data` are stable in that cycle, and hold until the next write.
- `wr_en` is high for exactly 1 cycle per word.
- `load_done` rises in the same cycle as the final `wr_en`. With the checksum feature, it instead rises one cycle after the checksum byte strobe.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Minimum spacing between `rx_valid` strobes: 1 cycle. Back-to-back strobes are legal.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit XOR accumulator folds every received program byte, including both HLT bytes.
  - After HLT, `RECV_CSUM` waits for one byte.
  - `checksum_err = (rx_data != acc)`. It is registered together with `load_done`.
  - After an overflow termination, no checksum byte is expected and `checksum_err` stays 0.
- Not defined: no accumulator, no `RECV_CSUM` state, and `checksum_err` is a constant 0. The port remains.

## Structure
- Shared package `bip_pkg` holds:
  - `ADDR_W`, `DATA_W` and `HLT_OPCODE` constants, shared with `program_memory` and the CPU decoder.
  - The loader state enum typedef.
- No sub-module: byte assembly, counter and checksum stay in one module.
- The top level connects `wr_*` to the program memory write port and holds the CPU until `load_done` is set.

## Test plan
- **Three-word load**: bytes 0x08,0x05, 0x18,0x03, 0x00,0x00 -> writes (0,0x0805), (1,0x1803), (2,0x0000); `load_done=1` in the cycle of the third `wr_en`; `word_count=3`.
- **Back-to-back strobes**: the same stream with `rx_valid` on consecutive cycles -> the identical three writes with no byte dropped; a high byte arriving in the `wr_en` cycle is accepted.
- **Overflow**: 2048 non-HLT words -> last write at address 2047; `overflow=1`, `load_done=1`, `word_count=2048`; a 2049th word produces no `wr_en`.
- **Reset mid-load**: send 0x12, assert `rst_n=0` for 1 cycle, then send 0x34,0x56 -> a single write (0,0x3456); all outputs were 0 during reset.
- **Checksum** (`PROGRAM_LOADER_CHECKSUM_EN`): stream 0x08,0x05,0x00,0x00 followed by checksum 0x0D -> `checksum_err=0`; repeating with checksum 0x0C -> `checksum_err=1`; in both cases `load_done` rises the cycle after the checksum strobe.
- **Post-DONE bytes**: 10 further strobes after `load_done` -> no `wr_en`, and all outputs unchanged.
